// File: rtl/data_mem_responder_pkg.sv
// Shared address map, status/control bit positions and region decode for the
// data-memory responder and anything that talks to it.
package data_mem_responder_pkg;

  localparam int TX_W = 8;

  localparam logic [15:0] MEM_MAP_GPIO   = 16'hFF00;
  localparam logic [15:0] MEM_MAP_TX     = 16'hFF04;
  localparam logic [15:0] MEM_MAP_CYCLES = 16'hFF08;
  localparam logic [15:0] MEM_MAP_CTRL   = 16'hFF0C;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_COUNT_LSB = 4;
  localparam int STAT_COUNT_W   = 5;

  localparam int CTRL_CLR_OVF_BIT = 0;
  localparam int CTRL_FLUSH_BIT   = 1;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_GPIO,
    REG_TX,
    REG_CYCLES,
    REG_CTRL,
    REG_NONE
  } region_e;

  // RAM occupies the bottom of the map; peripherals are matched on the word address.
  function automatic region_e decode_region(input logic [15:0] addr,
                                            input int unsigned ram_bytes);
    region_e r;
    if (32'(addr) < ram_bytes) begin
      r = REG_RAM;
    end else begin
      case (addr[15:2])
        MEM_MAP_GPIO[15:2]:   r = REG_GPIO;
        MEM_MAP_TX[15:2]:     r = REG_TX;
        MEM_MAP_CYCLES[15:2]: r = REG_CYCLES;
        MEM_MAP_CTRL[15:2]:   r = REG_CTRL;
        default:              r = REG_NONE;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO feeding the external TX consumer. Flush beats push/pop; a push
// into a full FIFO is only accepted when a pop frees a slot in the same cycle.
module tx_fifo
  import data_mem_responder_pkg::*;
#(
  parameter  int FIFO_DEPTH = 4,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_push,
  input  logic [TX_W-1:0] i_push_data,
  input  logic            i_pop,
  input  logic            i_flush,
  input  logic            i_clr_ovf,
  output logic [TX_W-1:0] o_head,
  output logic            o_empty,
  output logic            o_full,
  output logic [CW-1:0]   o_count,
  output logic            o_overflow
);

  logic [TX_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && (!w_full || w_pop);

  // Storage is reset so the head byte reads 0 out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Sticky overflow: set by a dropped push, cleared only by an explicit clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf <= 1'b0;
    end else if (i_clr_ovf) begin
      r_ovf <= 1'b0;
    end else if (i_push && w_full && !w_pop && !i_flush) begin
      r_ovf <= 1'b1;
    end
  end

  assign o_head     = r_mem[r_rd_ptr];
  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_count    = r_count;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/data_mem_responder.sv
// Target end of the core's load/store bus: word RAM plus a peripheral page
// (GPIO, cycle counter, TX FIFO). Read data is purely combinational because
// the core captures it on the next rising edge.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        CK_REF,
  input  logic        RST_N,
  input  logic        HALT,
  input  logic        MEM_ACCESS_READ_WRN,
  input  logic [15:0] MEM_ACCESS_ADDRESS_BUS,
  input  logic [31:0] MEM_ACCESS_DATA_OUT_BUS,
  output logic [31:0] MEM_ACCESS_DATA_IN_BUS,
  output logic [31:0] GPIO_OUT,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY
);

  localparam int          RAM_AW    = $clog2(DEPTH_WORDS);
  localparam int          FIFO_CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned RAM_BYTES = DEPTH_WORDS * 4;

  logic [31:0] r_ram [DEPTH_WORDS];
  logic [31:0] r_gpio;
  logic [31:0] r_cycles;

  region_e            w_region;
  logic [RAM_AW-1:0]  w_ram_idx;
  logic               w_we;
  logic               w_push;
  logic               w_ctrl_wr;
  logic               w_flush;
  logic               w_clr_ovf;
  logic               w_pop;
  logic [TX_W-1:0]    w_head;
  logic               w_empty;
  logic               w_full;
  logic [FIFO_CW-1:0] w_count;
  logic               w_ovf;
  logic [31:0]        w_status;

  assign w_region  = decode_region(MEM_ACCESS_ADDRESS_BUS, RAM_BYTES);
  assign w_ram_idx = MEM_ACCESS_ADDRESS_BUS[RAM_AW+1:2];
  assign w_we      = !MEM_ACCESS_READ_WRN && !HALT;
  assign w_push    = w_we && (w_region == REG_TX);
  assign w_ctrl_wr = w_we && (w_region == REG_CTRL);
  assign w_flush   = w_ctrl_wr && MEM_ACCESS_DATA_OUT_BUS[CTRL_FLUSH_BIT];
  assign w_clr_ovf = w_ctrl_wr && MEM_ACCESS_DATA_OUT_BUS[CTRL_CLR_OVF_BIT];
  assign w_pop     = TX_VALID && TX_READY;

  tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .i_clk       (CK_REF),
    .i_rst_n     (RST_N),
    .i_push      (w_push),
    .i_push_data (MEM_ACCESS_DATA_OUT_BUS[TX_W-1:0]),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .i_clr_ovf   (w_clr_ovf),
    .o_head      (w_head),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_count     (w_count),
    .o_overflow  (w_ovf)
  );

  assign TX_DATA  = w_head;
  assign TX_VALID = !w_empty;

  // RAM contents are deliberately not reset.
  always_ff @(posedge CK_REF) begin
    if (w_we && (w_region == REG_RAM)) r_ram[w_ram_idx] <= MEM_ACCESS_DATA_OUT_BUS;
  end

  // GPIO output register.
  always_ff @(posedge CK_REF or negedge RST_N) begin
    if (!RST_N) begin
      r_gpio <= '0;
    end else if (w_we && (w_region == REG_GPIO)) begin
      r_gpio <= MEM_ACCESS_DATA_OUT_BUS;
    end
  end

  // Free-running cycle counter, frozen while the core is halted; wraps at 2^32.
  always_ff @(posedge CK_REF or negedge RST_N) begin
    if (!RST_N) begin
      r_cycles <= '0;
    end else if (!HALT) begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  assign GPIO_OUT = r_gpio;

  // FIFO status word.
  always_comb begin
    w_status = '0;
    w_status[STAT_EMPTY_BIT] = w_empty;
    w_status[STAT_FULL_BIT]  = w_full;
    w_status[STAT_OVF_BIT]   = w_ovf;
    w_status[STAT_COUNT_LSB +: FIFO_CW] = w_count;
  end

  // Read mux; independent of READ_WRN so a read-during-write sees the old value.
  always_comb begin
    MEM_ACCESS_DATA_IN_BUS = '0;
    case (w_region)
      REG_RAM:    MEM_ACCESS_DATA_IN_BUS = r_ram[w_ram_idx];
      REG_GPIO:   MEM_ACCESS_DATA_IN_BUS = r_gpio;
      REG_TX:     MEM_ACCESS_DATA_IN_BUS = w_status;
      REG_CYCLES: MEM_ACCESS_DATA_IN_BUS = r_cycles;
      default:    MEM_ACCESS_DATA_IN_BUS = '0;
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder. Inputs change 1 time unit after the
// rising edge; outputs are sampled mid-cycle.
module tb_data_mem_responder;

  logic        CK_REF = 1'b0;
  logic        RST_N  = 1'b0;
  logic        HALT   = 1'b0;
  logic        MEM_ACCESS_READ_WRN = 1'b1;
  logic [15:0] MEM_ACCESS_ADDRESS_BUS = 16'h0000;
  logic [31:0] MEM_ACCESS_DATA_OUT_BUS = 32'h0;
  logic [31:0] MEM_ACCESS_DATA_IN_BUS;
  logic [31:0] GPIO_OUT;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference cycle count: increments on every un-halted edge out of reset.
  logic [31:0] m_cycles;

  data_mem_responder #(
    .DEPTH_WORDS (1024),
    .FIFO_DEPTH  (4)
  ) dut (
    .CK_REF                  (CK_REF),
    .RST_N                   (RST_N),
    .HALT                    (HALT),
    .MEM_ACCESS_READ_WRN     (MEM_ACCESS_READ_WRN),
    .MEM_ACCESS_ADDRESS_BUS  (MEM_ACCESS_ADDRESS_BUS),
    .MEM_ACCESS_DATA_OUT_BUS (MEM_ACCESS_DATA_OUT_BUS),
    .MEM_ACCESS_DATA_IN_BUS  (MEM_ACCESS_DATA_IN_BUS),
    .GPIO_OUT                (GPIO_OUT),
    .TX_DATA                 (TX_DATA),
    .TX_VALID                (TX_VALID),
    .TX_READY                (TX_READY)
  );

  always #5 CK_REF = ~CK_REF;

  always @(posedge CK_REF or negedge RST_N) begin
    if (!RST_N) m_cycles <= 32'h0;
    else if (!HALT) m_cycles <= m_cycles + 32'd1;
  end

  task automatic tick();
    @(posedge CK_REF);
    #1;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
    MEM_ACCESS_READ_WRN = 1'b0;
    MEM_ACCESS_ADDRESS_BUS = a;
    MEM_ACCESS_DATA_OUT_BUS = d;
  endtask

  task automatic bus_rd(input logic [15:0] a);
    MEM_ACCESS_READ_WRN = 1'b1;
    MEM_ACCESS_ADDRESS_BUS = a;
    MEM_ACCESS_DATA_OUT_BUS = 32'h0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    bus_rd(16'hFF04);
    tick(); tick();
    #3;
    n_checks++; if (MEM_ACCESS_DATA_IN_BUS !== 32'h1) begin n_fail++; $display("FAIL rst_status: got %h exp %h", MEM_ACCESS_DATA_IN_BUS, 32'h1); end
    n_checks++; if (GPIO_OUT !== 32'h0) begin n_fail++; $display("FAIL rst_gpio: got %h exp %h", GPIO_OUT, 32'h0); end
    n_checks++; if (TX_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %b exp 0", TX_VALID); end
    n_checks++; if (TX_DATA !== 8'h0) begin n_fail++; $display("FAIL rst_tx_data: got %h exp 00", TX_DATA); end
    bus_rd(16'hFF08);
    #1;
    n_checks++; if (MEM_ACCESS_DATA_IN_BUS !== 32'h0) begin n_fail++; $display("FAIL rst_cycles: got %h exp 0", MEM_ACCESS_DATA_IN_BUS); end
    tick();
    RST_N = 1'b1;
    bus_rd(16'h0000);
  endtask

  task automatic test_ram_gpio();
    bus_wr(16'h0010, 32'hDEADBEEF); tick();
    bus_rd(16'h0010); #3;
    n_checks++; if (MEM_ACCESS_DATA_IN_BUS !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ram_wr_rd: got %h exp %h", MEM_ACCESS_DATA_IN_BUS, 32'hDEADBEEF); end
    tick();
    bus_wr(16'h0010, 32'h12345678); #3;
    n_checks++; if (MEM_ACCESS_DATA_IN_BUS !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ram_rdw_old: got %h exp %h", MEM_ACCESS_DATA_IN_BUS, 32'hDEADBEEF); end
    tick();
    bus_rd(16'h0013); #3;
    n_checks++; if (MEM_ACCESS_DATA_IN_BUS !== 32'h12345678) begin n_fail++; $display("FAIL ram_rdw_new: got %h exp %h", MEM_ACCESS_DATA_IN_BUS, 32'h12345678); end
    tick();
    bus_wr(16'h0000, 32'h0BADF00D); tick();
    bus_wr(16'h1000, 32'h0000CAFE); tick();
    bus_rd(16'h0000); #3;
    n_checks++; if (MEM_ACCESS_DATA_IN_BUS !== 32'h0BADF00D) begin n_fail++; $display("FAIL ram_bound_alias: got %h exp %h", MEM_ACCESS_DATA_IN_BUS, 32'h0BADF00D); end
    tick();
    bus_rd(16'h1000); #3;
    n_checks++; if (MEM_ACCESS_DATA_IN_BUS !== 32'h0) begin n_fail++; $display("FAIL ram_bound_unmapped: got %h exp 0", MEM_ACCESS_DATA_IN_BUS); end
    tick();
    bus_wr(16'hFF00, 32'hA5A50001); #3;
    n_checks++; if (GPIO_OUT !== 32'h0) begin n_fail++; $display("FAIL gpio_before_edge: got %h exp 0", GPIO_OUT); end
    tick();
    bus_rd(16'hFF00); #3;
    n_checks++; if (GPIO_OUT !== 32'hA5A50001) begin n_fail++; $display("FAIL gpio_out: got %h exp %h", GPIO_OUT, 32'hA5A50001); end
    n_checks++; if (MEM_ACCESS_DATA_IN_BUS !== 32'hA5A50001) begin n_fail++; $display("FAIL gpio_rd: got %h exp %h", MEM_ACCESS_DATA_IN_BUS, 32'hA5A50001); end
    tick();
    bus_wr(16'hFF10, 32'hFFFFFFFF); tick();
    bus_rd(16'hFF10); #3;
    n_checks++; if (MEM_ACCESS_DATA_IN_BUS !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd: got %h exp 0", MEM_ACCESS_DATA_IN_BUS); end
    tick();
    bus_wr(16'hFF08, 32'hFFFFFFFF); tick();
    bus_wr(16'hFF0C, 32'h0); tick();
    bus_rd(16'hFF08); #3;
    n_checks++; if (MEM_ACCESS_DATA_IN_BUS !== m_cycles) begin n_fail++; $display("FAIL cycles_wr_ignored: got %h exp %h", MEM_ACCESS_DATA_IN_BUS, m_cycles); end
    bus_rd(16'hFF0C); #1;
    n_checks++; if (MEM_ACCESS_DATA_IN_BUS !== 32'h0) begin n_fail++; $display("FAIL ctrl_rd_zero: got %h exp 0", MEM_ACCESS_DATA_IN_BUS); end
    tick();
  endtask

  task automatic test_halt();
    logic [31:0] c0;
    HALT = 1'b1;
    c0 = m_cycles;
    bus_wr(16'hFF00, 32'h55); tick();
    bus_wr(16'hFF04, 32'h55); tick();
    bus_rd(16'hFF08); #3;
    n_checks++; if (MEM_ACCESS_DATA_IN_BUS !== c0) begin n_fail++; $display("FAIL halt_cycles_frozen: got %h exp %h", MEM_ACCESS_DATA_IN_BUS, c0); end
    n_checks++; if (GPIO_OUT !== 32'hA5A50001) begin n_fail++; $display("FAIL halt_gpio: got %h exp %h", GPIO_OUT, 32'hA5A50001); end
    tick();
    bus_rd(16'hFF04); #3;
    n_checks++; if (MEM_ACCESS_DATA_IN_BUS !== 32'h1) begin n_fail++; $display("FAIL halt_fifo_status: got %h exp %h", MEM_ACCESS_DATA_IN_BUS, 32'h1); end
    n_checks++; if (TX_VALID !== 1'b0) begin n_fail++; $display("FAIL halt_tx_valid: got %b exp 0", TX_VALID); end
    tick();
    HALT = 1'b0;
    bus_rd(16'hFF08); #3;
    n_checks++; if (MEM_ACCESS_DATA_IN_BUS !== c0) begin n_fail++; $display("FAIL halt_release_same: got %h exp %h", MEM_ACCESS_DATA_IN_BUS, c0); end
    tick(); #3;
    n_checks++; if (MEM_ACCESS_DATA_IN_BUS !== c0 + 32'd1) begin n_fail++; $display("FAIL halt_release_inc: got %h exp %h", MEM_ACCESS_DATA_IN_BUS, c0 + 32'd1); end
    tick();
  endtask

  task automatic test_fifo_fill_drain();
    logic [7:0] exp_seq [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    TX_READY = 1'b0;
    bus_wr(16'hFF04, 32'h11); #3;
    n_checks++; if (TX_VALID !== 1'b0) begin n_fail++; $display("FAIL push_valid_early: got %b exp 0", TX_VALID); end
    tick();
    bus_wr(16'hFF04, 32'h22); #3;
    n_checks++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h11) begin n_fail++; $display("FAIL push_valid_late: got v=%b d=%h exp v=1 d=11", TX_VALID, TX_DATA); end
    tick();
    bus_wr(16'hFF04, 32'h33); tick();
    bus_wr(16'hFF04, 32'h44); tick();
    bus_wr(16'hFF04, 32'h55); tick();
    bus_rd(16'hFF04); #3;
    n_checks++; if (MEM_ACCESS_DATA_IN_BUS !== 32'h46) begin n_fail++; $display("FAIL full_status: got %h exp %h", MEM_ACCESS_DATA_IN_BUS, 32'h46); end
    n_checks++; if (TX_DATA !== 8'h11) begin n_fail++; $display("FAIL head_stable: got %h exp 11", TX_DATA); end
    tick();
    TX_READY = 1'b1;
    bus_rd(16'h0000);
    for (int i = 0; i < 4; i++) begin
      #3;
      n_checks++; if (TX_VALID !== 1'b1 || TX_DATA !== exp_seq[i]) begin n_fail++; $display("FAIL drain_%0d: got v=%b d=%h exp v=1 d=%h", i, TX_VALID, TX_DATA, exp_seq[i]); end
      tick();
    end
    #3;
    n_checks++; if (TX_VALID !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b exp 0", TX_VALID); end
    TX_READY = 1'b0;
    tick();
    bus_rd(16'hFF04); #3;
    n_checks++; if (MEM_ACCESS_DATA_IN_BUS !== 32'h5) begin n_fail++; $display("FAIL drained_status: got %h exp %h", MEM_ACCESS_DATA_IN_BUS, 32'h5); end
    tick();
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_seq [4] = '{8'hBB, 8'hCC, 8'hDD, 8'h66};
    bus_wr(16'hFF0C, 32'h1); tick();
    bus_rd(16'hFF04); #3;
    n_checks++; if (MEM_ACCESS_DATA_IN_BUS !== 32'h1) begin n_fail++; $display("FAIL ovf_clear: got %h exp %h", MEM_ACCESS_DATA_IN_BUS, 32'h1); end
    tick();
    bus_wr(16'hFF04, 32'hAA); tick();
    bus_wr(16'hFF04, 32'hBB); tick();
    bus_wr(16'hFF04, 32'hCC); tick();
    bus_wr(16'hFF04, 32'hDD); tick();
    TX_READY = 1'b1;
    bus_wr(16'hFF04, 32'h66); #3;
    n_checks++; if (TX_DATA !== 8'hAA) begin n_fail++; $display("FAIL pp_head: got %h exp aa", TX_DATA); end
    tick();
    TX_READY = 1'b0;
    bus_rd(16'hFF04); #3;
    n_checks++; if (MEM_ACCESS_DATA_IN_BUS !== 32'h42) begin n_fail++; $display("FAIL pp_status: got %h exp %h", MEM_ACCESS_DATA_IN_BUS, 32'h42); end
    tick();
    TX_READY = 1'b1;
    bus_rd(16'h0000);
    for (int i = 0; i < 4; i++) begin
      #3;
      n_checks++; if (TX_VALID !== 1'b1 || TX_DATA !== exp_seq[i]) begin n_fail++; $display("FAIL pp_drain_%0d: got v=%b d=%h exp v=1 d=%h", i, TX_VALID, TX_DATA, exp_seq[i]); end
      tick();
    end
    #3;
    n_checks++; if (TX_VALID !== 1'b0) begin n_fail++; $display("FAIL pp_empty: got %b exp 0", TX_VALID); end
    TX_READY = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 5; i++) begin
      bus_wr(16'hFF04, 32'(i)); tick();
    end
    TX_READY = 1'b1;
    bus_wr(16'hFF0C, 32'h3); #3;
    n_checks++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h01) begin n_fail++; $display("FAIL flush_pre: got v=%b d=%h exp v=1 d=01", TX_VALID, TX_DATA); end
    tick();
    TX_READY = 1'b0;
    bus_rd(16'hFF04); #3;
    n_checks++; if (TX_VALID !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b exp 0", TX_VALID); end
    n_checks++; if (MEM_ACCESS_DATA_IN_BUS !== 32'h1) begin n_fail++; $display("FAIL flush_clr_status: got %h exp %h", MEM_ACCESS_DATA_IN_BUS, 32'h1); end
    tick();
    for (int i = 1; i <= 5; i++) begin
      bus_wr(16'hFF04, 32'(i + 8)); tick();
    end
    bus_wr(16'hFF0C, 32'h2); tick();
    bus_rd(16'hFF04); #3;
    n_checks++; if (MEM_ACCESS_DATA_IN_BUS !== 32'h5) begin n_fail++; $display("FAIL flush_keeps_ovf: got %h exp %h", MEM_ACCESS_DATA_IN_BUS, 32'h5); end
    tick();
    bus_wr(16'hFF0C, 32'h1); tick();
  endtask

  task automatic test_reset_midstream();
    int guard;
    bus_wr(16'hFF04, 32'h01); tick();
    bus_wr(16'hFF04, 32'h02); tick();
    bus_wr(16'hFF04, 32'h03); tick();
    bus_wr(16'hFF00, 32'h00001234); tick();
    bus_rd(16'hFF08);
    guard = 0;
    while (m_cycles != 32'h100 && guard < 2000) begin
      tick();
      guard++;
    end
    n_checks++; if (guard >= 2000) begin n_fail++; $display("FAIL wait_cycles_timeout: got %h exp %h", m_cycles, 32'h100); end
    #3;
    n_checks++; if (MEM_ACCESS_DATA_IN_BUS !== 32'h100) begin n_fail++; $display("FAIL mid_cycles: got %h exp %h", MEM_ACCESS_DATA_IN_BUS, 32'h100); end
    n_checks++; if (TX_VALID !== 1'b1 || GPIO_OUT !== 32'h1234) begin n_fail++; $display("FAIL mid_pre: got v=%b gpio=%h exp v=1 gpio=00001234", TX_VALID, GPIO_OUT); end
    RST_N = 1'b0;
    #2;
    n_checks++; if (TX_VALID !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b exp 0", TX_VALID); end
    n_checks++; if (GPIO_OUT !== 32'h0) begin n_fail++; $display("FAIL mid_rst_gpio: got %h exp 0", GPIO_OUT); end
    n_checks++; if (MEM_ACCESS_DATA_IN_BUS !== 32'h0) begin n_fail++; $display("FAIL mid_rst_cycles: got %h exp 0", MEM_ACCESS_DATA_IN_BUS); end
    bus_rd(16'hFF04); #1;
    n_checks++; if (MEM_ACCESS_DATA_IN_BUS !== 32'h1) begin n_fail++; $display("FAIL mid_rst_status: got %h exp %h", MEM_ACCESS_DATA_IN_BUS, 32'h1); end
    bus_rd(16'hF000); #1;
    n_checks++; if (MEM_ACCESS_DATA_IN_BUS !== 32'h0) begin n_fail++; $display("FAIL mid_rst_unmapped: got %h exp 0", MEM_ACCESS_DATA_IN_BUS); end
    tick();
    RST_N = 1'b1;
    bus_rd(16'h0000);
    tick();
  endtask

  initial begin
    test_reset();
    test_ram_gpio();
    test_halt();
    test_fifo_fill_drain();
    test_full_push_pop();
    test_flush();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
